// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the fetch-redirect slice of the 16-bit core.
//   Contents:
//     pc_state_t            - FSM states of the PC / redirect unit
//     PC_WIDTH_DEFAULT      - default PC / instruction-address width (word address)
//     RESET_VECTOR_DEFAULT  - default PC value after reset
//     FLUSH_CYCLES_DEFAULT  - default number of wrong-path slots squashed per redirect
//     FLUSH_CNT_WIDTH       - width of the flush-window counter (covers 1..7)
//     flush_count()         - turns the FLUSH_CYCLES parameter into a counter load value
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int          PC_WIDTH_DEFAULT     = 16;
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;
  localparam int          FLUSH_CYCLES_DEFAULT = 2;
  localparam int          FLUSH_CNT_WIDTH      = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,  // sequential fetch, redirect / halt accepted
    ST_FLUSH  = 2'd1,  // squashing wrong-path instructions after a redirect
    ST_HALTED = 2'd2   // core stopped; only reset leaves this state
  } pc_state_t;

  // Clamp the flush depth to the range the counter can represent. A depth of
  // zero would make the FLUSH state unreachable-to-exit, so 1 is the minimum.
  function automatic logic [FLUSH_CNT_WIDTH-1:0] flush_count(input int cycles);
    if (cycles < 1) begin
      return FLUSH_CNT_WIDTH'(1);
    end else if (cycles > 7) begin
      return FLUSH_CNT_WIDTH'(7);
    end else begin
      return FLUSH_CNT_WIDTH'(cycles);
    end
  endfunction

endpackage : cpu_pkg

// File: rtl/pc_redirect_if.sv
// -----------------------------------------------------------------------------
// pc_redirect_if
//   Bundle of the control/data signals between decode/execute, the PC unit
//   and instruction fetch. Clock and reset are kept outside the bundle.
//   Signals (direction as seen by the PC unit):
//     stall_pi            in  : pipeline stall, PC and flush counter hold
//     is_branch_taken_pi  in  : taken decision from the branch comparator
//     branch_pc_pi        in  : PC of the resolving branch
//     branch_offset_pi    in  : signed offset relative to branch_pc_pi + 1
//     is_jump_pi          in  : absolute jump request from decode
//     jump_target_pi      in  : absolute jump target
//     halt_pi             in  : halt instruction decoded
//     pc_po               out : registered fetch address
//     fetch_valid_po      out : pc_po is a real fetch this cycle
//     flush_po            out : squash the instruction(s) in flight
//     halted_po           out : core halted
//   Modports:
//     master - the pipeline side that drives requests and observes the PC
//     slave  - the PC / redirect unit
// -----------------------------------------------------------------------------
interface pc_redirect_if
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
);

  logic                stall_pi;
  logic                is_branch_taken_pi;
  logic [PC_WIDTH-1:0] branch_pc_pi;
  logic [PC_WIDTH-1:0] branch_offset_pi;
  logic                is_jump_pi;
  logic [PC_WIDTH-1:0] jump_target_pi;
  logic                halt_pi;
  logic [PC_WIDTH-1:0] pc_po;
  logic                fetch_valid_po;
  logic                flush_po;
  logic                halted_po;

  modport master (
    output stall_pi,
    output is_branch_taken_pi,
    output branch_pc_pi,
    output branch_offset_pi,
    output is_jump_pi,
    output jump_target_pi,
    output halt_pi,
    input  pc_po,
    input  fetch_valid_po,
    input  flush_po,
    input  halted_po
  );

  modport slave (
    input  stall_pi,
    input  is_branch_taken_pi,
    input  branch_pc_pi,
    input  branch_offset_pi,
    input  is_jump_pi,
    input  jump_target_pi,
    input  halt_pi,
    output pc_po,
    output fetch_valid_po,
    output flush_po,
    output halted_po
  );

endinterface : pc_redirect_if

// File: rtl/branch_target_calc.sv
// -----------------------------------------------------------------------------
// branch_target_calc
//   Purely combinational PC-relative target adder:
//     o_target = i_branch_pc + 1 + i_branch_offset  (mod 2^PC_WIDTH)
//   The offset is two's complement, so a plain modular add covers both
//   forward and backward branches; wrap-around is silent by design.
//   Ports:
//     i_branch_pc      in  PC_WIDTH : PC of the resolving branch
//     i_branch_offset  in  PC_WIDTH : signed offset relative to the next PC
//     o_target         out PC_WIDTH : branch target address
// -----------------------------------------------------------------------------
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [PC_WIDTH-1:0] i_branch_pc,
  input  logic [PC_WIDTH-1:0] i_branch_offset,
  output logic [PC_WIDTH-1:0] o_target
);

  logic [PC_WIDTH-1:0] w_next_pc;

  assign w_next_pc = i_branch_pc + PC_WIDTH'(1);
  assign o_target  = w_next_pc + i_branch_offset;

endmodule : branch_target_calc

// File: rtl/pc_redirect.sv
// -----------------------------------------------------------------------------
// pc_redirect
//   Program counter and fetch-redirect unit. Owns the PC register, selects
//   between sequential fetch, a PC-relative branch target and an absolute
//   jump target, and opens a flush window after every redirect so that the
//   wrong-path instructions already fetched get squashed.
//
//   FSM:
//     RUN    - redirect (branch beats jump) -> load target, open flush window
//              else halt                    -> HALTED, PC holds
//              else !stall                  -> PC + 1
//     FLUSH  - redirect/halt inputs ignored (they come from squashed slots);
//              each unstalled cycle advances PC and burns one flush slot
//     HALTED - everything frozen until reset
//
//   All outputs come straight from flops; there is no input->output path.
//
//   Ports:
//     clk_pi    in : clock, rising edge
//     reset_pi  in : synchronous, active-high reset (highest priority)
//     bus       slave modport of pc_redirect_if (see interface header)
//
//   Parameters:
//     PC_WIDTH      PC / address width
//     RESET_VECTOR  PC value after reset
//     FLUSH_CYCLES  wrong-path slots squashed per redirect (1..7)
// -----------------------------------------------------------------------------
module pc_redirect
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT),
  parameter int                  FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic          clk_pi,
  input  logic          reset_pi,
  pc_redirect_if.slave  bus
);

  localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = flush_count(FLUSH_CYCLES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pc_state_t                  r_state;
  logic [PC_WIDTH-1:0]        r_pc;
  logic [FLUSH_CNT_WIDTH-1:0] r_flush_cnt;
  logic                       r_fetch_valid;
  logic                       r_flush;
  logic                       r_halted;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  pc_state_t                  w_state_nxt;
  logic [PC_WIDTH-1:0]        w_pc_nxt;
  logic [FLUSH_CNT_WIDTH-1:0] w_flush_cnt_nxt;

  logic [PC_WIDTH-1:0]        w_branch_target;
  logic [PC_WIDTH-1:0]        w_redirect_target;
  logic [PC_WIDTH-1:0]        w_pc_inc;
  logic                       w_redirect;

  // ---------------------------------------------------------------------------
  // Target computation
  // ---------------------------------------------------------------------------
  branch_target_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_branch_target_calc (
    .i_branch_pc     (bus.branch_pc_pi),
    .i_branch_offset (bus.branch_offset_pi),
    .o_target        (w_branch_target)
  );

  assign w_redirect = bus.is_branch_taken_pi | bus.is_jump_pi;

  // The branch comparator resolves an older instruction than the decode-stage
  // jump, so when both fire the jump itself is on the wrong path.
  assign w_redirect_target = bus.is_branch_taken_pi ? w_branch_target
                                                    : bus.jump_target_pi;

  assign w_pc_inc = r_pc + PC_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_flush_cnt_nxt = r_flush_cnt;

    unique case (r_state)
      ST_RUN: begin
        // Redirect is honoured even under stall: the branch has resolved and
        // the fetch stream must change regardless of back-pressure.
        if (w_redirect) begin
          w_pc_nxt        = w_redirect_target;
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_state_nxt     = ST_FLUSH;
        end else if (bus.halt_pi) begin
          w_state_nxt = ST_HALTED;
        end else if (!bus.stall_pi) begin
          w_pc_nxt = w_pc_inc;
        end
      end

      ST_FLUSH: begin
        if (!bus.stall_pi) begin
          w_pc_nxt = w_pc_inc;
          // Leaving on the last slot (rather than one cycle after the count
          // hits zero) lets a new redirect land with no dead cycle.
          if (r_flush_cnt <= FLUSH_CNT_WIDTH'(1)) begin
            w_flush_cnt_nxt = '0;
            w_state_nxt     = ST_RUN;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_WIDTH'(1);
          end
        end
      end

      ST_HALTED: begin
        // Frozen: defaults already hold PC, counter and state.
      end

      default: begin
        // Unused encoding: recover into RUN rather than lock up.
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (outputs are registered from the next state so they line up
  // with the PC they describe)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pi) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (reset_pi) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_VECTOR;
      r_flush_cnt   <= '0;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_fetch_valid <= (w_state_nxt != ST_HALTED);
      r_flush       <= (w_state_nxt == ST_FLUSH);
      r_halted      <= (w_state_nxt == ST_HALTED);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc_po          = r_pc;
  assign bus.fetch_valid_po = r_fetch_valid;
  assign bus.flush_po       = r_flush;
  assign bus.halted_po      = r_halted;

endmodule : pc_redirect

// File: tb/tb_pc_redirect.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect
//   Directed bench for pc_redirect (PC_WIDTH=16, RESET_VECTOR=0, FLUSH_CYCLES=2).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that same
//   point, i.e. they show the state loaded by the edge just passed.
//   Observed/expected values are packed as {pc[15:0], 4'b0 v f h}: the last
//   hex digit is {0, fetch_valid, flush, halted} (4 = valid, 6 = valid+flush,
//   1 = halted, 0 = reset).
// -----------------------------------------------------------------------------
module tb_pc_redirect;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [19:0] exp_v;

  pc_redirect_if #(.PC_WIDTH(16)) bus ();

  pc_redirect #(
    .PC_WIDTH     (16),
    .RESET_VECTOR (16'h0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk_pi   (clk),
    .reset_pi (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] obs();
    return {bus.pc_po, 1'b0, bus.fetch_valid_po, bus.flush_po, bus.halted_po};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_pi           = 1'b0;
    bus.is_branch_taken_pi = 1'b0;
    bus.branch_pc_pi       = 16'h0000;
    bus.branch_offset_pi   = 16'h0000;
    bus.is_jump_pi         = 1'b0;
    bus.jump_target_pi     = 16'h0000;
    bus.halt_pi            = 1'b0;
  endtask

  // Absolute jump, held for one edge only.
  task automatic jump_once(input logic [15:0] tgt);
    bus.is_jump_pi     = 1'b1;
    bus.jump_target_pi = tgt;
    tick();
    bus.is_jump_pi     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {16'h0000, 4'h0}; n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL rst_%0d: observed %h expected %h", i, obs(), exp_v); end
    end
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_v = {16'(i), 4'h4}; n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL seq_%0d: observed %h expected %h", i, obs(), exp_v); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_taken_branch();
    // pc = 0x0005 here; 0x0010 + 1 + (-4) = 0x000D
    bus.is_branch_taken_pi = 1'b1;
    bus.branch_pc_pi       = 16'h0010;
    bus.branch_offset_pi   = 16'hFFFC;
    tick();
    bus.is_branch_taken_pi = 1'b0;
    exp_v = {16'h000D, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL br_n1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h000E, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL br_n2: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h000F, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL br_n3: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0010, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL br_n4: observed %h expected %h", obs(), exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_in_flush();
    bus.is_branch_taken_pi = 1'b1;
    bus.branch_pc_pi       = 16'h0010;
    bus.branch_offset_pi   = 16'hFFFC;
    tick();
    bus.is_branch_taken_pi = 1'b0;
    exp_v = {16'h000D, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_redir: observed %h expected %h", obs(), exp_v); end
    bus.stall_pi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = {16'h000D, 4'h6}; n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL stl_hold_%0d: observed %h expected %h", i, obs(), exp_v); end
    end
    bus.stall_pi = 1'b0;
    tick();
    exp_v = {16'h000E, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_rel1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h000F, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_rel2: observed %h expected %h", obs(), exp_v); end

    // Stall in RUN holds the PC; a redirect under stall is still taken.
    bus.stall_pi = 1'b1;
    tick();
    exp_v = {16'h000F, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_run: observed %h expected %h", obs(), exp_v); end
    jump_once(16'h0123);
    exp_v = {16'h0123, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_jump: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0123, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_jhold: observed %h expected %h", obs(), exp_v); end
    bus.stall_pi = 1'b0;
    tick();
    exp_v = {16'h0124, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_j1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0125, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stl_j2: observed %h expected %h", obs(), exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignored_in_flush();
    // 0x0020 + 1 + 0x0010 = 0x0031
    bus.is_branch_taken_pi = 1'b1;
    bus.branch_pc_pi       = 16'h0020;
    bus.branch_offset_pi   = 16'h0010;
    tick();
    bus.is_branch_taken_pi = 1'b0;
    exp_v = {16'h0031, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL ign_redir: observed %h expected %h", obs(), exp_v); end
    // Jump and halt held across both flush edges: both must be ignored.
    bus.is_jump_pi     = 1'b1;
    bus.jump_target_pi = 16'h0100;
    bus.halt_pi        = 1'b1;
    tick();
    exp_v = {16'h0032, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL ign_f1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0033, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL ign_f2: observed %h expected %h", obs(), exp_v); end
    clear_inputs();
    tick();
    exp_v = {16'h0034, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL ign_run: observed %h expected %h", obs(), exp_v); end

    // Branch + halt in the same RUN cycle: redirect wins, halt dropped.
    bus.is_branch_taken_pi = 1'b1;
    bus.branch_pc_pi       = 16'h0040;
    bus.branch_offset_pi   = 16'h0005;
    bus.halt_pi            = 1'b1;
    tick();
    clear_inputs();
    exp_v = {16'h0046, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL brhalt_1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0047, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL brhalt_2: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0048, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL brhalt_3: observed %h expected %h", obs(), exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    jump_once(16'h0300);
    exp_v = {16'h0300, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_j1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0301, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_f1: observed %h expected %h", obs(), exp_v); end
    // Held jump: ignored on the last flush edge, taken on the first RUN edge.
    bus.is_jump_pi     = 1'b1;
    bus.jump_target_pi = 16'h0400;
    tick();
    exp_v = {16'h0302, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_f2: observed %h expected %h", obs(), exp_v); end
    tick();
    bus.is_jump_pi = 1'b0;
    exp_v = {16'h0400, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_j2: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0401, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_f3: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0402, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_run: observed %h expected %h", obs(), exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap_priority();
    jump_once(16'hFFFD);
    tick();
    tick();
    exp_v = {16'hFFFF, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_ffff: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0000, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_0000: observed %h expected %h", obs(), exp_v); end

    // Jump to 0x0200 together with taken branch to 0x004A + 1 + 5 = 0x0050.
    bus.is_jump_pi         = 1'b1;
    bus.jump_target_pi     = 16'h0200;
    bus.is_branch_taken_pi = 1'b1;
    bus.branch_pc_pi       = 16'h004A;
    bus.branch_offset_pi   = 16'h0005;
    tick();
    clear_inputs();
    exp_v = {16'h0050, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL prio_br: observed %h expected %h", obs(), exp_v); end
    tick();
    tick();
    exp_v = {16'h0052, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL prio_end: observed %h expected %h", obs(), exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_halt_reset();
    jump_once(16'h0005);
    tick();
    tick();
    exp_v = {16'h0007, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL hlt_pre: observed %h expected %h", obs(), exp_v); end
    bus.halt_pi = 1'b1;
    tick();
    exp_v = {16'h0007, 4'h1}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL hlt_enter: observed %h expected %h", obs(), exp_v); end
    // Hammer the halted core with redirects and stall toggles.
    bus.halt_pi            = 1'b0;
    bus.is_jump_pi         = 1'b1;
    bus.jump_target_pi     = 16'h0999;
    bus.is_branch_taken_pi = 1'b1;
    bus.branch_pc_pi       = 16'h0100;
    bus.branch_offset_pi   = 16'h0010;
    for (int i = 0; i < 10; i++) begin
      bus.stall_pi = i[0];
      tick();
      exp_v = {16'h0007, 4'h1}; n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL hlt_frz_%0d: observed %h expected %h", i, obs(), exp_v); end
    end
    reset = 1'b1;
    clear_inputs();
    tick();
    exp_v = {16'h0000, 4'h0}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL hlt_rst: observed %h expected %h", obs(), exp_v); end
    reset = 1'b0;
    tick();
    exp_v = {16'h0001, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL hlt_rel: observed %h expected %h", obs(), exp_v); end

    // Reset in the middle of a flush window.
    jump_once(16'h0700);
    exp_v = {16'h0700, 4'h6}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL fl_redir: observed %h expected %h", obs(), exp_v); end
    reset = 1'b1;
    tick();
    exp_v = {16'h0000, 4'h0}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL fl_rst: observed %h expected %h", obs(), exp_v); end
    reset = 1'b0;
    tick();
    exp_v = {16'h0001, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL fl_rel1: observed %h expected %h", obs(), exp_v); end
    tick();
    exp_v = {16'h0002, 4'h4}; n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL fl_rel2: observed %h expected %h", obs(), exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_taken_branch();
    test_stall_in_flush();
    test_ignored_in_flush();
    test_back_to_back();
    test_wrap_priority();
    test_halt_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pc_redirect

// File: doc/pc_redirect.md
# pc_redirect

Program-counter and fetch-redirect unit for the 16-bit processor: consumes the branch-comparator decision (`is_branch_taken`) and the decode-stage jump request. It owns the PC register, computes branch targets, and generates the flush window that squashes wrong-path instructions. It sits between decode/execute and instruction memory, on the receiving end of the branch decision.

## Interface
- `PC_WIDTH`, 16, PC and address width (word-addressed)
- `RESET_VECTOR`, 16'h0000, PC value after reset
- `FLUSH_CYCLES`, 2, wrong-path instructions squashed per redirect (1..7)

- `clk_pi` in 1: single clock, rising edge
- `reset_pi` in 1: synchronous, active-high reset
- `stall_pi` in 1: pipeline stall; PC and flush counter hold
- `is_branch_taken_pi` in 1: taken-branch decision from branch comparator
- `branch_pc_pi` in PC_WIDTH: PC of the resolving branch instruction
- `branch_offset_pi` in PC_WIDTH: signed offset, relative to `branch_pc_pi + 1`
- `is_jump_pi` in 1: absolute jump request
- `jump_target_pi` in PC_WIDTH: absolute jump target
- `halt_pi` in 1: halt instruction decoded
- `pc_po` out PC_WIDTH: fetch address (registered)
- `fetch_valid_po` out 1: `pc_po` is a real fetch this cycle
- `flush_po` out 1: squash the instruction(s) currently in flight
- `halted_po` out 1: core halted

## Operation
- States: RUN, FLUSH, HALTED. Reset → RUN, `pc_po = RESET_VECTOR`, `flush_po = 0`, `halted_po = 0`, `fetch_valid_po = 0` during the reset cycle and 1 from the first post-reset cycle.
- Branch target = `branch_pc_pi + 1 + branch_offset_pi`, modulo 2^PC_WIDTH (wraps silently; no overflow flag).
- Redirect = `is_branch_taken_pi | is_jump_pi`. If both are set, the branch wins.
- RUN:
  - redirect → `pc <= target`; flush counter `<= FLUSH_CYCLES`; go to FLUSH. Redirect applies even when `stall_pi = 1`.
  - else `halt_pi` → go to HALTED; pc holds.
  - else if `!stall_pi` → `pc <= pc + 1`, wrapping 16'hFFFF → 16'h0000.
  - else hold.
- FLUSH:
  - `flush_po = 1`.
  - All redirect and halt inputs are ignored, because they come from squashed instructions.
  - If `!stall_pi`: `pc <= pc + 1` and counter decrements. When the counter would reach 0, go to RUN.
  - While stalled, pc and counter hold and `flush_po` stays 1.
- HALTED:
  - `halted_po = 1`, `fetch_valid_po = 0`, pc frozen.
  - All inputs are ignored; only `reset_pi` exits.
- Redirect and halt in the same RUN cycle: the redirect wins and halt is dropped (wrong-path halt).
- Reset has priority over everything in every state, including mid-FLUSH. The counter is cleared to 0.

## Timing
- Inputs are sampled on the rising edge. All outputs are registered; there are no combinational input→output paths.
- Redirect sampled at edge N: `pc_po = target` from cycle N+1. `flush_po = 1` for exactly FLUSH_CYCLES unstalled cycles, starting at N+1.
- Back-to-back redirect: the first redirect after FLUSH returns to RUN is honored with no dead cycle.
- Halt sampled at edge N: `halted_po = 1` and `fetch_valid_po = 0` from N+1.
- Sequential fetch throughput: 1 address per unstalled cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - the `pc_state_t` enum (RUN, FLUSH, HALTED)
  - `PC_WIDTH_DEFAULT`
  - `RESET_VECTOR_DEFAULT`
- One sub-module, `branch_target_calc`: combinational `branch_pc + 1 + offset`, instantiated once.
- The FSM, counter and PC register live in `pc_redirect`.

## Test plan
- **Reset and sequential fetch:** reset 2 cycles, then 5 unstalled cycles → `pc_po` 0,1,2,3,4,5; `fetch_valid_po = 0` only in the reset cycle.
- **Taken branch:** `branch_pc = 16'h0010`, offset = 16'hFFFC (−4), taken at N → `pc_po = 16'h000D` at N+1; `flush_po` high at N+1 and N+2; `pc_po = 16'h000F` at N+3 with `flush_po = 0`.
- **Stall inside flush:** as above, with stall asserted at N+1 for 3 cycles → `flush_po` stays 1 and `pc_po` holds 16'h000D through the stall; flush ends 2 unstalled cycles later.
- **Ignored inputs during flush:** jump to 16'h0100 and halt during FLUSH → both ignored. Branch taken plus halt in the same RUN cycle → redirect taken, `halted_po` stays 0.
- **Wrap and jump priority:** PC at 16'hFFFF unstalled → 16'h0000. Jump to 16'h0200 together with a taken branch whose target is 16'h0050 → `pc_po = 16'h0050`.
- **Halt and reset:** halt at PC 16'h0007 → `halted_po = 1` and PC frozen for 10 cycles despite stimulus. Reset asserted mid-HALTED and mid-FLUSH → `pc_po = RESET_VECTOR`, all flags 0 the next cycle.
